// File: rtl/seq_pair_pkg.sv
// Shared definitions for the dual sequence-detector pair controller.
//   state_e    : controller states (IDLE, ARM, WAIT2, DONE)
//   MODE_*     : classification codes returned on res_mode
//   SRC_CH1/2  : bit positions of the per-channel hit flags in res_src
package seq_pair_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        WAIT2 = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [1:0] MODE_NONE = 2'd0;
    localparam logic [1:0] MODE_ONE  = 2'd1;
    localparam logic [1:0] MODE_BOTH = 2'd2;

    localparam int SRC_CH1 = 0;
    localparam int SRC_CH2 = 1;

endpackage

// File: rtl/seq_pair_timer.sv
// Saturating cycle counter shared by the ARM and WAIT2 phases.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force count to 0 (wins over en)
//   en         : advance by one, never past limit
//   limit      : terminal value selected by the controller
//   cnt        : current count
//   at_limit   : cnt == limit
module seq_pair_timer
    import seq_pair_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt,
    output logic             at_limit
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign at_limit = (cnt_q == limit);
    assign cnt      = cnt_q;

    // The bound is checked before incrementing so the count can never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !at_limit) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_pair_ctrl.sv
// Measurement controller for the two serial sequence detectors.
// Arms on start, times the second channel hit against the first within a
// bounded window, and presents one classified result on a valid/ready port.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, abort      : begin a run (IDLE only) / cancel any run
//   ok1, ok2          : detector hit pulses
//   n1, n2            : detector 4-bit shift-window snapshots
//   busy              : controller is not idle
//   res_valid/ready   : result handshake
//   res_mode          : 0 no hit, 1 one channel, 2 both channels
//   res_xor           : latched n1 XOR latched n2
//   res_lat           : cycles from first to second hit (WINDOW on timeout)
//   res_src           : bit0 channel-1 hit, bit1 channel-2 hit
module seq_pair_ctrl
    import seq_pair_pkg::*;
#(
    parameter int MAX_BITS = 64,
    parameter int WINDOW   = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             ok1,
    input  logic             ok2,
    input  logic [3:0]       n1,
    input  logic [3:0]       n2,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [1:0]       res_mode,
    output logic [3:0]       res_xor,
    output logic [CNT_W-1:0] res_lat,
    output logic [1:0]       res_src
);

    localparam logic [CNT_W-1:0] ARM_LIMIT  = CNT_W'(MAX_BITS - 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] WINDOW_LAT = CNT_W'(WINDOW);

    state_e           state_q, state_d;
    logic [3:0]       snap1_q, snap1_d;
    logic [3:0]       snap2_q, snap2_d;
    logic [1:0]       hit_q, hit_d;
    logic             busy_q, busy_d;
    logic             res_valid_q, res_valid_d;
    logic [1:0]       res_mode_q, res_mode_d;
    logic [3:0]       res_xor_q, res_xor_d;
    logic [CNT_W-1:0] res_lat_q, res_lat_d;
    logic [1:0]       res_src_q, res_src_d;

    logic             tmr_clr, tmr_en, tmr_at_limit;
    logic [CNT_W-1:0] tmr_limit, tmr_cnt;

    logic             go_done;
    logic [1:0]       done_mode, done_src;
    logic [CNT_W-1:0] done_lat;
    logic             other_ok;

    seq_pair_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (tmr_clr),
        .en       (tmr_en),
        .limit    (tmr_limit),
        .cnt      (tmr_cnt),
        .at_limit (tmr_at_limit)
    );

    always_comb begin
        state_d   = state_q;
        snap1_d   = snap1_q;
        snap2_d   = snap2_q;
        hit_d     = hit_q;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
        tmr_limit = (state_q == WAIT2) ? WAIT_LIMIT : ARM_LIMIT;
        go_done   = 1'b0;
        done_mode = MODE_NONE;
        done_src  = 2'b00;
        done_lat  = '0;
        // In WAIT2 only the channel that has not yet hit matters; repeat
        // pulses on the first channel are deliberately not looked at.
        other_ok  = hit_q[SRC_CH1] ? ok2 : ok1;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = ARM;
                    tmr_clr = 1'b1;
                    hit_d   = 2'b00;
                end
            end
            ARM: begin
                // Hits are tested ahead of the count limit so that a hit in
                // the final count cycle wins over the timeout.
                if (abort) begin
                    state_d = IDLE;
                end else if (ok1 && ok2) begin
                    snap1_d   = n1;
                    snap2_d   = n2;
                    go_done   = 1'b1;
                    done_mode = MODE_BOTH;
                    done_src  = 2'b11;
                end else if (ok1) begin
                    snap1_d          = n1;
                    hit_d[SRC_CH1]   = 1'b1;
                    tmr_clr          = 1'b1;
                    state_d          = WAIT2;
                end else if (ok2) begin
                    snap2_d          = n2;
                    hit_d[SRC_CH2]   = 1'b1;
                    tmr_clr          = 1'b1;
                    state_d          = WAIT2;
                end else if (tmr_at_limit) begin
                    snap1_d   = n1;
                    snap2_d   = n2;
                    go_done   = 1'b1;
                    done_mode = MODE_NONE;
                    done_src  = 2'b00;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            WAIT2: begin
                // The timer reads 0 in the first WAIT2 cycle, so the hit
                // distance is one more than the current count.
                if (abort) begin
                    state_d = IDLE;
                end else if (other_ok || tmr_at_limit) begin
                    if (hit_q[SRC_CH1]) begin
                        snap2_d = n2;
                    end else begin
                        snap1_d = n1;
                    end
                    go_done = 1'b1;
                    if (other_ok) begin
                        done_mode = MODE_BOTH;
                        done_src  = 2'b11;
                        done_lat  = tmr_cnt + CNT_W'(1);
                    end else begin
                        done_mode = MODE_ONE;
                        done_src  = hit_q;
                        done_lat  = WINDOW_LAT;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            DONE: begin
                if (abort || res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (go_done) begin
            state_d = DONE;
        end

        busy_d      = (state_d != IDLE);
        res_valid_d = (state_d == DONE);

        // Result fields only move on DONE entry so they are stable while valid.
        res_mode_d = res_mode_q;
        res_src_d  = res_src_q;
        res_lat_d  = res_lat_q;
        res_xor_d  = res_xor_q;
        if (go_done) begin
            res_mode_d = done_mode;
            res_src_d  = done_src;
            res_lat_d  = done_lat;
            res_xor_d  = snap1_d ^ snap2_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            snap1_q     <= '0;
            snap2_q     <= '0;
            hit_q       <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_mode_q  <= '0;
            res_xor_q   <= '0;
            res_lat_q   <= '0;
            res_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            snap1_q     <= snap1_d;
            snap2_q     <= snap2_d;
            hit_q       <= hit_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_mode_q  <= res_mode_d;
            res_xor_q   <= res_xor_d;
            res_lat_q   <= res_lat_d;
            res_src_q   <= res_src_d;
        end
    end

    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_mode  = res_mode_q;
    assign res_xor   = res_xor_q;
    assign res_lat   = res_lat_q;
    assign res_src   = res_src_q;

endmodule

// File: tb/tb_seq_pair_ctrl.sv
// Self-checking bench for seq_pair_ctrl. Two behavioural 1011 detectors
// feed the controller from per-channel bit streams; expected results are
// queued when a run is launched and compared when res_valid rises.
`timescale 1ns/1ps
module tb_seq_pair_ctrl;

    localparam int MAX_BITS = 64;
    localparam int WINDOW   = 8;
    localparam int CNT_W    = 8;
    localparam int NV       = 11;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             res_ready = 1'b1;
    logic             ok1, ok2;
    logic [3:0]       n1, n2;
    logic             busy, res_valid;
    logic [1:0]       res_mode, res_src;
    logic [3:0]       res_xor;
    logic [CNT_W-1:0] res_lat;
    logic             b1 = 1'b0;
    logic             b2 = 1'b0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         o1a;      // start cycle of first 1011 on ch1 (-1 none)
        int         o1b;      // start cycle of second 1011 on ch1 (-1 none)
        int         o2;       // start cycle of 1011 on ch2 (-1 none)
        int         done_at;  // clock edge (after start capture) entering DONE
        logic [1:0] mode;
        logic [1:0] src;
        int         lat;
        logic [3:0] xr;
    } vec_t;

    typedef struct {
        int         done_at;
        logic [1:0] mode;
        logic [1:0] src;
        int         lat;
        logic [3:0] xr;
    } exp_t;

    vec_t vecs [NV];
    exp_t exp_q [$];

    always #5 clk = ~clk;

    seq_pair_ctrl #(
        .MAX_BITS (MAX_BITS),
        .WINDOW   (WINDOW),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .ok1       (ok1),
        .ok2       (ok2),
        .n1        (n1),
        .n2        (n2),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_mode  (res_mode),
        .res_xor   (res_xor),
        .res_lat   (res_lat),
        .res_src   (res_src)
    );

    // Detector stand-ins: shift one bit per cycle, flag 1011 the cycle after.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n1  <= 4'b0000;
            n2  <= 4'b0000;
            ok1 <= 1'b0;
            ok2 <= 1'b0;
        end else begin
            n1  <= {n1[2:0], b1};
            n2  <= {n2[2:0], b2};
            ok1 <= ({n1[2:0], b1} == 4'b1011);
            ok2 <= ({n2[2:0], b2} == 4'b1011);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic pat_bit(input int o, input int c);
        logic [3:0] p;
        p = 4'b1011;
        if (o < 0 || c < o || c > o + 3) return 1'b0;
        return p[3 - (c - o)];
    endfunction

    // Launch a run, stream the channel patterns, stop at the first negedge
    // where res_valid is seen and score the result.
    task automatic collect(input vec_t v, input string tag);
        exp_t e;
        bit   got;
        int   done_c;
        e.done_at = v.done_at;
        e.mode    = v.mode;
        e.src     = v.src;
        e.lat     = v.lat;
        e.xr      = v.xr;
        exp_q.push_back(e);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        got    = 1'b0;
        done_c = -1;
        for (int c = 0; c < 200; c++) begin
            if (res_valid) begin
                got    = 1'b1;
                done_c = c;
                break;
            end
            b1 = pat_bit(v.o1a, c) | pat_bit(v.o1b, c);
            b2 = pat_bit(v.o2, c);
            @(negedge clk);
        end
        b1 = 1'b0;
        b2 = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: res_valid=0 after 200 cycles, required 1", tag);
            exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            check({tag, "_cycle"}, 32'(done_c), 32'(e.done_at));
            check({tag, "_mode"},  32'(res_mode), 32'(e.mode));
            check({tag, "_src"},   32'(res_src),  32'(e.src));
            check({tag, "_lat"},   32'(res_lat),  32'(e.lat));
            check({tag, "_xor"},   32'(res_xor),  32'(e.xr));
            check({tag, "_busy"},  32'(busy),     32'd1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_mode"},  32'(res_mode),  32'd0);
        check({tag, "_src"},   32'(res_src),   32'd0);
        check({tag, "_lat"},   32'(res_lat),   32'd0);
        check({tag, "_xor"},   32'(res_xor),   32'd0);
    endtask

    initial begin
        bit seen;
        //           o1a o1b  o2 done mode   src    lat xor
        vecs[0]  = '{  0, -1,  0,   5, 2'd2, 2'b11, 0, 4'b0000};  // simultaneous
        vecs[1]  = '{  0, -1,  3,   8, 2'd2, 2'b11, 3, 4'b0000};  // ch2 late by 3
        vecs[2]  = '{  3, -1,  0,   8, 2'd2, 2'b11, 3, 4'b0000};  // ch1 late by 3
        vecs[3]  = '{  0, -1, -1,  13, 2'd1, 2'b01, 8, 4'b1011};  // ch1 only
        vecs[4]  = '{ -1, -1,  2,  15, 2'd1, 2'b10, 8, 4'b1011};  // ch2 only
        vecs[5]  = '{  0,  4,  6,  11, 2'd2, 2'b11, 6, 4'b0000};  // ch1 repeat ignored
        vecs[6]  = '{  0, -1,  8,  13, 2'd2, 2'b11, 8, 4'b0000};  // hit at count WINDOW
        vecs[7]  = '{  0, -1,  9,  13, 2'd1, 2'b01, 8, 4'b1110};  // one cycle too late
        vecs[8]  = '{ -1, -1, -1,  64, 2'd0, 2'b00, 0, 4'b0000};  // no hit
        vecs[9]  = '{ 59, -1, -1,  72, 2'd1, 2'b01, 8, 4'b1011};  // hit on count 63
        vecs[10] = '{ 60, -1, -1,  64, 2'd0, 2'b00, 0, 4'b0101};  // hit one cycle late

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven runs
        for (int i = 0; i < NV; i++) begin
            collect(vecs[i], $sformatf("vec%0d", i));
            repeat (8) @(negedge clk);
            check($sformatf("vec%0d_idle", i), 32'(busy), 32'd0);
        end

        // abort beats start in IDLE
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_beats_start", 32'(busy), 32'd0);

        // abort during WAIT2
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 7; c++) begin
            b1 = pat_bit(0, c);
            @(negedge clk);
        end
        b1 = 1'b0;
        check("wait2_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(res_valid), 32'd0);
        seen = 1'b0;
        repeat (16) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        check("abort_no_result", 32'(seen), 32'd0);

        // Backpressure: result held, start pulses ignored
        res_ready = 1'b0;
        collect(vecs[0], "bp");
        for (int k = 0; k < 5; k++) begin
            start = 1'b1;
            @(negedge clk);
            check($sformatf("bp_hold%0d_valid", k), 32'(res_valid), 32'd1);
            check($sformatf("bp_hold%0d_mode", k),  32'(res_mode),  32'd2);
            check($sformatf("bp_hold%0d_src", k),   32'(res_src),   32'd3);
            check($sformatf("bp_hold%0d_lat", k),   32'(res_lat),   32'd0);
            check($sformatf("bp_hold%0d_xor", k),   32'(res_xor),   32'd0);
        end
        start = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(res_valid), 32'd0);
        check("bp_release_busy",  32'(busy),      32'd0);
        @(negedge clk);
        check("bp_no_queued_start", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of ARM
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        check("midarm_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midarm_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        collect(vecs[1], "post_rst");
        repeat (8) @(negedge clk);

        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_pair_ctrl.md
Name: seq_pair_ctrl

Overview:
Arbitration and scheduling controller for the dual serial sequence-detector datapath. It arms a measurement on request and watches the two detectors' ok flags and 4-bit window snapshots. It times the second detection against the first within a bounded window and returns one classified result (mode, XOR, latency, source) over a valid/ready handshake. It sits between the two detector instances and the result-consuming logic, replacing the free-running combinational checker for measured runs.

Parameters:
MAX_BITS, 64, max clk cycles spent in ARM without any hit before a mode-0 result
WINDOW, 8, max clk cycles after the first hit to wait for the other channel
CNT_W, 8, counter width; must satisfy MAX_BITS < 2**CNT_W and WINDOW < 2**CNT_W

Ports:
clk  in  1  clock; one serial bit per cycle on each channel
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request a measurement; honoured only in IDLE
abort  in  1  cancel any run; return to IDLE next cycle
ok1  in  1  channel-1 detector hit (high the cycle after the 4th pattern bit)
ok2  in  1  channel-2 detector hit
n1  in  4  channel-1 shift-window snapshot
n2  in  4  channel-2 shift-window snapshot
busy  out  1  high in ARM, WAIT2 or DONE
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_mode  out  2  0 none, 1 one channel, 2 both
res_xor  out  4  latched n1 XOR latched n2
res_lat  out  CNT_W  cycles from first to second hit
res_src  out  2  bit0 = ch1 hit, bit1 = ch2 hit

Behaviour:
- Reset: state IDLE; all outputs 0; snapshot regs and counters 0. Async assert, sync-to-clk deassert not required.
- All outputs registered. res_* change only on entry to DONE and hold stable while res_valid=1.
- States IDLE, ARM, WAIT2, DONE (encoding in package).
- IDLE: start=1 and abort=0 -> ARM; cnt<=0. abort beats start.
- ARM, evaluated each cycle:
  - ok1&ok2: latch n1 and n2; src=11, lat=0, mode=2 -> DONE.
  - Exactly one ok: latch that channel's n; set its src bit; cnt<=0 -> WAIT2.
  - No hit with cnt==MAX_BITS-1: latch current n1 and n2; src=00, mode=0, lat=0 -> DONE.
  - Otherwise cnt++.
  - A hit in the final count cycle wins over the timeout.
- WAIT2: cnt counts cycles since the first hit, 1..WINDOW.
  - Other channel's ok at count k: latch its n; src=11, mode=2, lat=k -> DONE.
  - Repeat pulses on the first channel are ignored; the first snapshot is kept.
  - No hit by count WINDOW: latch the missing channel's current n; mode=1, lat=WINDOW -> DONE.
  - A hit at count WINDOW wins over the timeout.
- DONE: res_valid=1; res_xor = snapshot1 ^ snapshot2.
  - res_valid&res_ready -> IDLE; res_valid drops the next cycle.
  - start while in DONE is ignored, not queued.
  - A new start is accepted no earlier than the cycle after return to IDLE.
- abort in ARM, WAIT2 or DONE -> IDLE next cycle; res_valid<=0; result discarded; busy<=0.
- busy = (state != IDLE).
- Counters never wrap: bounds are checked before increment.

Decomposition:
- Package seq_pair_pkg: state enum {IDLE, ARM, WAIT2, DONE}; mode constants MODE_NONE=0, MODE_ONE=1, MODE_BOTH=2; src bit indices.
- One natural sub-module, seq_pair_timer: a CNT_W counter with clear, enable and terminal-compare (limit input).
  - Used for both the ARM limit and the WAIT2 limit, selected by the FSM.

Test Plan:
- Simultaneous hit: start, then 1,0,1,1 on both channels from the next cycle -> res_valid with mode=2, src=11, lat=0, xor=0000.
- Skew: ch2 delayed 3 cycles -> mode=2, src=11, lat=3, xor=0000; extra ch1 hits during WAIT2 do not change the result.
- Single channel: ch1 sends 1011, ch2 all zeros -> after WINDOW=8 cycles: mode=1, src=01, lat=8, xor=1011.
- No hit: both channels held at 0 -> DONE exactly 64 cycles after ARM entry: mode=0, src=00, xor=0000; ch1 hit on count 63 gives mode-1 flow instead.
- Backpressure: res_ready low for 5 cycles -> res_* stable, start pulses ignored; ready high -> IDLE, res_valid=0 the next cycle.
- abort during WAIT2 -> IDLE, no res_valid. rst_n asserted mid-ARM -> all outputs 0 immediately; a fresh start then measures normally.
